// File: rtl/repack_last_if.sv
// Stream bundle for repack_last: narrow input beats in, wide packed words out.
interface repack_last_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
);
  logic           s_stb;
  logic [W-1:0]   s_dat;
  logic           s_last;
  logic           s_rdy;
  logic           m_rdy;
  logic           m_stb;
  logic [W*D-1:0] m_dat;
  logic [D-1:0]   m_keep;
  logic           m_last;

  modport master (
    output s_stb, s_dat, s_last, m_rdy,
    input  s_rdy, m_stb, m_dat, m_keep, m_last
  );

  modport slave (
    input  s_stb, s_dat, s_last, m_rdy,
    output s_rdy, m_stb, m_dat, m_keep, m_last
  );
endinterface

// File: rtl/repack_last.sv
// Narrow-to-wide stream packer: D beats of W bits form one word, lane 0 first;
// s_last closes a group early and m_keep marks the lanes that hold real beats.
module repack_last #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         rst,
  repack_last_if.slave bus,
  output logic         busy
);
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned DW = W * D;

  logic [DW-1:0] acc;
  logic [IW-1:0] idx;
  logic          m_stb_q;
  logic [DW-1:0] m_dat_q;
  logic [D-1:0]  m_keep_q;
  logic          m_last_q;

  logic          s_in;
  logic          m_out;
  logic          done;
  logic [DW-1:0] word_c;
  logic [D-1:0]  keep_c;

  assign bus.s_rdy  = ~m_stb_q | bus.m_rdy;
  assign bus.m_stb  = m_stb_q;
  assign bus.m_dat  = m_dat_q;
  assign bus.m_keep = m_keep_q;
  assign bus.m_last = m_last_q;
  assign busy       = (idx != '0);

  assign s_in  = bus.s_stb & bus.s_rdy;
  assign m_out = m_stb_q & bus.m_rdy;
  assign done  = s_in & ((idx == IW'(D - 1)) | bus.s_last);

  // Word as it would be emitted now: held lanes below idx, incoming beat at idx, zeros above.
  always_comb begin
    word_c = '0;
    keep_c = '0;
    for (int unsigned k = 0; k < D; k++) begin
      if (IW'(k) < idx) begin
        word_c[W*k +: W] = acc[W*k +: W];
        keep_c[k]        = 1'b1;
      end else if (IW'(k) == idx) begin
        word_c[W*k +: W] = bus.s_dat;
        keep_c[k]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      idx      <= '0;
      m_stb_q  <= 1'b0;
      m_dat_q  <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      if (done) begin
        m_dat_q  <= word_c;
        m_keep_q <= keep_c;
        m_last_q <= bus.s_last;
        m_stb_q  <= 1'b1;
        acc      <= '0;
        idx      <= '0;
      end else begin
        if (m_out) m_stb_q <= 1'b0;
        if (s_in) begin
          for (int unsigned k = 0; k < D; k++) begin
            if (IW'(k) == idx) acc[W*k +: W] <= bus.s_dat;
          end
          idx <= idx + IW'(1);
        end
      end
    end
  end
endmodule

// File: doc/repack_last.md
# repack_last

Parametrised narrow-to-wide stream packer with early termination. It collects `D` input beats of `W` bits into one `W*D`-bit output word, placing the first beat in the least-significant lane. An input `s_last` flag closes a group early; the word is then emitted with a lane-valid mask. The block sits between a narrow producer (byte or sample stream) and a wide consumer. It sustains one input beat per clock under a continuously ready sink.

## Interface
Parameters:
- `W`, 8: input beat width in bits (≥1).
- `D`, 4: lanes per output word (≥2; need not be a power of two). Index width is `$clog2(D)`.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserted (0) clears all state immediately. Deassertion is synchronous to the design.
- `s_stb`  in  1  input beat valid.
- `s_dat`  in  W  input beat data.
- `s_last`  in  1  the beat with this flag set closes the current group.
- `s_rdy`  out  1  input ready.
- `m_rdy`  in  1  output ready.
- `m_stb`  out  1  output word valid.
- `m_dat`  out  W*D  packed word; lane k is `m_dat[W*k +: W]`.
- `m_keep`  out  D  lane-valid mask; bit k set means lane k holds a real beat.
- `m_last`  out  1  the word was closed by `s_last`.
- `busy`  out  1  a partial group is held in the accumulator (index ≠ 0).

## Operation
- Internal state: accumulator `acc` (W*D bits), lane index `idx` (0..D-1), and the output registers.
- An input handshake (`s_in`) is `s_stb & s_rdy`. An output handshake (`m_out`) is `m_stb & m_rdy`.
- `s_rdy = ~m_stb | m_rdy`. It is purely combinational on output state and independent of `s_stb`, `s_dat` and `s_last`.
- A handshake is a **completing** beat when `s_in` holds and either `idx == D-1` or `s_last` is set.
- Non-completing `s_in`:
  - `acc` lane `idx` ← `s_dat`.
  - `idx` ← `idx + 1`.
- Completing `s_in`:
  - `m_dat` ← `acc` with lane `idx` replaced by `s_dat`. Lanes above `idx` are driven to 0.
  - `m_keep` ← ones in bits 0..`idx`, zeros above.
  - `m_last` ← `s_last`.
  - `m_stb` ← 1.
  - `acc` ← 0 and `idx` ← 0.
- When `m_out` occurs without a completing `s_in` in the same cycle, `m_stb` ← 0. `m_dat`, `m_keep` and `m_last` hold their values; they are don't-care once `m_stb` is 0.
- When `m_out` and a completing `s_in` occur in the same cycle, the new word replaces the old one and `m_stb` stays 1. There is no bubble.
- While `m_stb & ~m_rdy`, `s_rdy` is 0 and no beat is accepted. `acc`, `idx` and all outputs hold.
- `s_last` on the first beat (`idx == 0`) produces a one-lane word: `m_keep` = 1 and the upper lanes are 0.
- `s_last` on lane D-1 produces a full word: `m_keep` is all ones and `m_last` = 1.
- `busy = (idx != 0)`.
- `s_dat` and `s_last` are ignored when `s_stb` = 0.

## Timing
- Reset values:
  - `m_stb` = 0, `m_dat` = 0, `m_keep` = 0, `m_last` = 0.
  - `idx` = 0, `acc` = 0, so `busy` = 0.
  - `s_rdy` = 1.
- Reset asserted mid-group or mid-stall discards the partial group and the pending word immediately, with no clock edge required. The first beat after reset lands in lane 0.
- Latency: `m_stb` rises on the clock edge of the completing handshake and is visible the cycle after it.
- Throughput: with `m_rdy` held at 1 and `s_stb` held at 1, one beat is accepted every cycle and one word is emitted every D cycles, or earlier on `s_last`.
- `m_stb`, once set, stays set with all output fields stable until `m_out` occurs.

## Test plan
- Full groups, W=8, D=4, `m_rdy`=1: send 0x01,0x02,0x03,0x04,0x05…0x08 on consecutive cycles → `m_dat`=0x04030201 then 0x08070605, `m_keep`=0xF, `m_last`=0. Each word appears one cycle after its 4th beat, and `s_rdy` stays 1 throughout.
- Early last: send 0xAA, then 0xBB with `s_last` → `m_dat`=0x0000BBAA, `m_keep`=0x3, `m_last`=1. The next beat 0xCC lands in lane 0.
- Backpressure: hold `m_rdy`=0 after the first word completes → `s_rdy`=0 and `m_dat` stays stable. Raise `m_rdy` for one cycle together with a completing beat → the old word is taken, the new word is presented the next cycle, and `m_stb` never drops.
- Single-beat last: `s_last` on the first beat with 0x5A → `m_dat`=0x0000005A, `m_keep`=0x1, `m_last`=1.
- Reset mid-group: accept 2 beats (`busy`=1), then pulse `rst` low between clock edges → `busy`, `m_stb` and `m_keep` drop to 0 immediately. The next 4 beats form a full word starting at lane 0.
- Non-power-of-two D=3, W=4: send 0x1,0x2,0x3 → `m_dat`=0x321, `m_keep`=0x7.
